// File: rtl/buffered_mul_pipe_pkg.sv
// Shared definitions for the buffered multiply pipeline: default sizing,
// multiply-unit FSM state encoding and the product-width helper.
package buffered_mul_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_MUL_LATENCY = 3;
  localparam int DEF_DEPTH       = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

  // Full-precision width of an unsigned WIDTH x WIDTH product.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/buffered_mul_pipe_result_fifo.sv
// Circular result queue for the multiply pipeline. Head reads as zero when
// empty; a push is only taken when a slot is free (or freed by a same-cycle
// pop), so nothing already queued can be overwritten.
module result_fifo #(
  parameter int WIDTH_D = 16,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH_D-1:0]       push_data,
  input  logic                     pop,
  output logic [WIDTH_D-1:0]       head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH_D-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               empty;
  logic               do_pop;
  logic               do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only observed through a valid head.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/buffered_mul_pipe.sv
// Buffered multiply pipeline: valid/ready operand intake, one multi-cycle
// multiply in flight, results queued in a DEPTH-entry FIFO.
// Build option CONST_TIME_EN: removes the zero-operand early exit so every
// operation takes exactly MUL_LATENCY cycles regardless of operand values.
module buffered_mul_pipe
  import buffered_mul_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int DEPTH       = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*WIDTH-1:0]      out_result
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = $clog2(MUL_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(MUL_LATENCY);

  mul_state_t           state;
  mul_state_t           state_nx;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nx;
  logic                 accept;
  logic                 done;
  logic                 vld_p0;
  logic                 fifo_full;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [PW-1:0]        prod_p0;

  // Unsigned full-precision product, never truncated.
  function automatic logic [PW-1:0] mul_full(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  assign in_ready  = (state == IDLE) && !fifo_full && rst_n;
  assign accept    = in_valid && in_ready;
  assign out_valid = (fifo_count != '0);

  // Stage p0: operands captured and multiplied at accept; held while busy.
  always_ff @(posedge clk) begin
    if (accept) prod_p0 <= mul_full(in_a, in_b);
  end

`ifdef CONST_TIME_EN
  assign done = (cnt == LAT);
`else
  logic zero_p0;

  // Zero-operand flag latched with the operands to allow the early exit.
  always_ff @(posedge clk) begin
    if (accept) zero_p0 <= (in_a == '0) || (in_b == '0);
  end

  assign done = (cnt == LAT) || zero_p0;
`endif

  // Multiply-unit state register and occupancy counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Next-state logic; vld_p0 marks the cycle prod_p0 is pushed to the queue.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    vld_p0   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = BUSY;
          cnt_nx   = CW'(1);
        end
      end
      BUSY: begin
        if (done) begin
          vld_p0   = 1'b1;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  result_fifo #(
    .WIDTH_D (PW),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (vld_p0),
    .push_data (prod_p0),
    .pop       (out_valid && out_ready),
    .head      (out_result),
    .full      (fifo_full),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_buffered_mul_pipe.sv
// Directed bench for buffered_mul_pipe (WIDTH=8, MUL_LATENCY=3, DEPTH=4).
module tb_buffered_mul_pipe;

  localparam int W = 8;
  localparam int L = 3;
  localparam int D = 4;
`ifdef CONST_TIME_EN
  localparam int EARLY = L;
`else
  localparam int EARLY = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_result;

  always #5 clk = ~clk;

  buffered_mul_pipe #(
    .WIDTH       (W),
    .MUL_LATENCY (L),
    .DEPTH       (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    int          lat;
  } vec_t;

  vec_t        vecs[7];
  logic [15:0] expq[$];
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 50) begin
      step;
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: in_ready timeout got 0 expected 1", name);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    wait_ready("issue");
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step;
    in_valid = 1'b0;
    in_a     = ~a;
    in_b     = ~b;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (expq.size() > 0 && n < 200) begin
      if (out_valid) chk(name, 32'(out_result), 32'(expq.pop_front()));
      step;
      n++;
    end
    if (expq.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: drain timeout got %0d left expected 0", name, expq.size());
      expq.delete();
    end
    chk({name, "_empty"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    int   n;
    logic bad;
    int   acc;
    int   cyc;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, L};
    vecs[1] = '{8'h03, 8'h05, 16'h000F, L};
    vecs[2] = '{8'h00, 8'h7A, 16'h0000, EARLY};
    vecs[3] = '{8'h7A, 8'h00, 16'h0000, EARLY};
    vecs[4] = '{8'h80, 8'h02, 16'h0100, L};
    vecs[5] = '{8'h01, 8'hFF, 16'h00FF, L};
    vecs[6] = '{8'h12, 8'h34, 16'h03A8, L};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    step; step; step;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", 32'(out_result), 32'd0);
    rst_n = 1'b1;
    step;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single operations from the vector table.
    for (int i = 0; i < 7; i++) begin
      wait_ready("vec");
      in_valid = 1'b1; in_a = vecs[i].a; in_b = vecs[i].b;
      step;
      in_valid = 1'b0; in_a = ~vecs[i].a; in_b = ~vecs[i].b;
      chk($sformatf("vec%0d_busy", i), 32'(in_ready), 32'd0);
      n = 0;
      while (!out_valid && n < 20) begin
        step;
        n++;
      end
      chk($sformatf("vec%0d_latency", i), 32'(n), 32'(vecs[i].lat));
      chk($sformatf("vec%0d_prod", i), 32'(out_result), 32'(vecs[i].prod));
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      chk($sformatf("vec%0d_popped", i), 32'(out_valid), 32'd0);
      chk($sformatf("vec%0d_zero", i), 32'(out_result), 32'd0);
    end

    // Reset one cycle after accepting 3*5 discards the operation.
    wait_ready("rstmid");
    in_valid = 1'b1; in_a = 8'h03; in_b = 8'h05;
    step;
    in_valid = 1'b0;
    rst_n = 1'b0;
    step;
    chk("rstmid_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    step;
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) bad = 1'b1;
      step;
    end
    chk("rstmid_no_push", 32'(bad), 32'd0);
    chk("rstmid_ready_after", 32'(in_ready), 32'd1);

    // Backpressure: four queued, fifth held off until a pop.
    out_ready = 1'b0;
    issue(8'h10, 8'h20);
    issue(8'h11, 8'h21);
    issue(8'h12, 8'h22);
    issue(8'h13, 8'h23);
    in_valid = 1'b1; in_a = 8'h14; in_b = 8'h24;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (in_ready) bad = 1'b1;
      step;
    end
    chk("full_in_ready_low", 32'(bad), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_head_oldest", 32'(out_result), 32'h0200);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("full_ready_after_pop", 32'(in_ready), 32'd1);
    chk("full_new_head", 32'(out_result), 32'h0231);
    step;
    in_valid = 1'b0;
    expq.push_back(16'h0231); expq.push_back(16'h0264);
    expq.push_back(16'h0299); expq.push_back(16'h02D0);
    drain("full_order");

    // Push edge coinciding with a pop keeps occupancy and order.
    issue(8'h03, 8'h05);
    issue(8'hFF, 8'hFF);
    issue(8'h80, 8'h02);
    issue(8'h12, 8'h34);
    step; step;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("pp_head", 32'(out_result), 32'hFE01);
    chk("pp_ready", 32'(in_ready), 32'd1);
    issue(8'h01, 8'hFF);
    for (int i = 0; i < L; i++) step;
    chk("pp_full_ready_low", 32'(in_ready), 32'd0);
    expq.push_back(16'hFE01); expq.push_back(16'h0100);
    expq.push_back(16'h03A8); expq.push_back(16'h00FF);
    drain("pp_order");

    // Random traffic against a queue model.
    acc = 0;
    cyc = 0;
    while ((acc < 100 || expq.size() > 0) && cyc < 5000) begin
      in_valid  = (acc < 100) && ($urandom_range(1, 0) == 1);
      in_a      = ($urandom_range(4, 0) == 0) ? 8'h00 : 8'($urandom);
      in_b      = ($urandom_range(4, 0) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(1, 0) == 1);
      #3;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL rand_extra: got %0h expected no result", out_result);
        end else begin
          chk("rand_prod", 32'(out_result), 32'(expq.pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(16'(in_a) * 16'(in_b));
        acc++;
      end
      step;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rand_complete", 32'((acc == 100) && (expq.size() == 0)), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
